// File: rtl/bank_pkg.sv
// Shared bank-level constants and encodings used by the bank datapath blocks.
package bank_pkg;

  localparam int DATA_W    = 128;
  localparam int WBUF_ID_W = 8;
  localparam int CH_ID_W   = 2;
  localparam int CH_NUM    = 4;

  typedef enum logic [1:0] {
    ISU_WRITE              = 2'd0,
    ISU_READ               = 2'd1,
    ISU_READ_WITH_LINEFILL = 2'd2,
    ISU_WRITE_BACK         = 2'd3
  } isu_opcode_e;

  typedef enum logic [1:0] {
    OFS_EMPTY = 2'd0,
    OFS_DIRTY = 2'd1,
    OFS_SYNC  = 2'd2
  } offset_state_e;

endpackage

// File: rtl/wbuf_free_picker.sv
// Lowest-index free-entry finder for one channel of the write buffer.
module wbuf_free_picker #(
  parameter int ENTRY_NUM = 4,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0] valid_i,
  output logic                 has_free_o,
  output logic [IDX_W-1:0]     idx_o
);

  // Scan from the top down so the last hit is the lowest clear bit.
  always_comb begin
    has_free_o = ~&valid_i;
    idx_o      = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bank_write_buffer.sv
// Per-bank write-data buffer: captures crossbar write payloads into
// per-channel entries, notifies the ISU of each buffered write and returns
// the data to the SRAM controller on fetch, freeing the entry.
module bank_write_buffer
  import bank_pkg::*;
#(
  parameter int ENTRY_NUM = 4,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 xbar_wbuf_valid_i,
  output logic                 xbar_wbuf_ready_o,
  input  logic [CH_ID_W-1:0]   xbar_wbuf_channel_id_i,
  input  logic [DATA_W-1:0]    xbar_wbuf_data_i,
  output logic                 wbuf_isu_valid_o,
  input  logic                 wbuf_isu_ready_i,
  output logic [CH_ID_W-1:0]   wbuf_isu_channel_id_o,
  output logic [WBUF_ID_W-1:0] wbuf_isu_wbuffer_id_o,
  input  logic                 rc_wbuf_req_valid_i,
  output logic                 rc_wbuf_req_ready_o,
  input  logic [CH_ID_W-1:0]   rc_wbuf_req_channel_id_i,
  input  logic [WBUF_ID_W-1:0] rc_wbuf_req_wbuffer_id_i,
  output logic                 rc_wbuf_rtn_valid_o,
  input  logic                 rc_wbuf_rtn_ready_i,
  output logic [DATA_W-1:0]    rc_wbuf_rtn_data_o,
  output logic                 wbuf_err_o
);

  logic [CH_NUM-1:0][ENTRY_NUM-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]                mem_q [CH_NUM][ENTRY_NUM];

  logic                notify_valid_q;
  logic [CH_ID_W-1:0]  notify_ch_q;
  logic [IDX_W-1:0]    notify_idx_q;

  logic                rtn_valid_q;
  logic [DATA_W-1:0]   rtn_data_q;
  logic                err_q;

  logic [CH_NUM-1:0]   has_free;
  logic [IDX_W-1:0]    free_idx [CH_NUM];

  logic                alloc;
  logic [IDX_W-1:0]    alloc_idx;
  logic                fetch_acc;
  logic                fetch_hit;
  logic [IDX_W-1:0]    fetch_idx;
  logic                fetch_id_hi_zero;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_pick
    wbuf_free_picker #(
      .ENTRY_NUM (ENTRY_NUM),
      .IDX_W     (IDX_W)
    ) u_pick (
      .valid_i    (valid_q[c]),
      .has_free_o (has_free[c]),
      .idx_o      (free_idx[c])
    );
  end

  // Readies are forced high during reset so upstream never sees a stale
  // full/busy indication from pre-reset state.
  assign alloc_idx         = free_idx[xbar_wbuf_channel_id_i];
  assign xbar_wbuf_ready_o = rst_i |
                             (has_free[xbar_wbuf_channel_id_i] &
                              (~notify_valid_q | wbuf_isu_ready_i));
  assign rc_wbuf_req_ready_o = rst_i | ~rtn_valid_q | rc_wbuf_rtn_ready_i;

  assign alloc     = xbar_wbuf_valid_i & xbar_wbuf_ready_o;
  assign fetch_acc = rc_wbuf_req_valid_i & rc_wbuf_req_ready_o;
  assign fetch_idx = rc_wbuf_req_wbuffer_id_i[IDX_W-1:0];
  assign fetch_id_hi_zero = ((rc_wbuf_req_wbuffer_id_i >> IDX_W) == '0);
  assign fetch_hit = fetch_id_hi_zero & valid_q[rc_wbuf_req_channel_id_i][fetch_idx];

  // Next valid vector: allocation picks from the start-of-cycle vector, so
  // an entry freed by a same-cycle fetch is only reusable next cycle.
  always_comb begin
    valid_d = valid_q;
    if (fetch_acc && fetch_hit) valid_d[rc_wbuf_req_channel_id_i][fetch_idx] = 1'b0;
    if (alloc) valid_d[xbar_wbuf_channel_id_i][alloc_idx] = 1'b1;
  end

  // Payload storage; entry contents are meaningful only while valid.
  always_ff @(posedge clk_i) begin
    if (alloc) mem_q[xbar_wbuf_channel_id_i][alloc_idx] <= xbar_wbuf_data_i;
  end

  // Control state: entry valids, ISU notify register, fetch return, error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q        <= '0;
      notify_valid_q <= 1'b0;
      notify_ch_q    <= '0;
      notify_idx_q   <= '0;
      rtn_valid_q    <= 1'b0;
      rtn_data_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (alloc) begin
        notify_valid_q <= 1'b1;
        notify_ch_q    <= xbar_wbuf_channel_id_i;
        notify_idx_q   <= alloc_idx;
      end else if (wbuf_isu_ready_i) begin
        notify_valid_q <= 1'b0;
      end
      if (fetch_acc) begin
        rtn_valid_q <= 1'b1;
        rtn_data_q  <= fetch_hit ? mem_q[rc_wbuf_req_channel_id_i][fetch_idx] : '0;
        if (!fetch_hit) err_q <= 1'b1;
      end else if (rc_wbuf_rtn_ready_i) begin
        rtn_valid_q <= 1'b0;
      end
    end
  end

  assign wbuf_isu_valid_o      = notify_valid_q;
  assign wbuf_isu_channel_id_o = notify_ch_q;
  assign wbuf_isu_wbuffer_id_o = {{(WBUF_ID_W-IDX_W){1'b0}}, notify_idx_q};
  assign rc_wbuf_rtn_valid_o   = rtn_valid_q;
  assign rc_wbuf_rtn_data_o    = rtn_data_q;
  assign wbuf_err_o            = err_q;

endmodule

// File: tb/tb_bank_write_buffer.sv
// Directed bench for bank_write_buffer with hand-computed expectations.
module tb_bank_write_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         xv, xr;
  logic [1:0]   xch;
  logic [127:0] xdata;
  logic         iv, ir;
  logic [1:0]   ich;
  logic [7:0]   iid;
  logic         qv, qr;
  logic [1:0]   qch;
  logic [7:0]   qid;
  logic         rv, rr;
  logic [127:0] rdata;
  logic         err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bank_write_buffer #(.ENTRY_NUM(4)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .xbar_wbuf_valid_i        (xv),
    .xbar_wbuf_ready_o        (xr),
    .xbar_wbuf_channel_id_i   (xch),
    .xbar_wbuf_data_i         (xdata),
    .wbuf_isu_valid_o         (iv),
    .wbuf_isu_ready_i         (ir),
    .wbuf_isu_channel_id_o    (ich),
    .wbuf_isu_wbuffer_id_o    (iid),
    .rc_wbuf_req_valid_i      (qv),
    .rc_wbuf_req_ready_o      (qr),
    .rc_wbuf_req_channel_id_i (qch),
    .rc_wbuf_req_wbuffer_id_i (qid),
    .rc_wbuf_rtn_valid_o      (rv),
    .rc_wbuf_rtn_ready_i      (rr),
    .rc_wbuf_rtn_data_o       (rdata),
    .wbuf_err_o               (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; xv = 1'b0; xch = '0; xdata = '0; ir = 1'b1;
    qv = 1'b0; qch = '0; qid = '0; rr = 1'b1;
    #1;
    chk("rst_xbar_ready", 128'(xr), 128'(1));
    chk("rst_req_ready", 128'(qr), 128'(1));
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_isu_valid", 128'(iv), 128'(0));
    chk("rst_rtn_valid", 128'(rv), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_rtn_data", rdata, 128'(0));
    chk("rst_isu_id", 128'({ich, iid}), 128'(0));

    // Fill channel 0 with 0xA..0xD, ISU always ready.
    for (int i = 0; i < 4; i++) begin
      xv = 1'b1; xch = 2'd0; xdata = 128'(10 + i);
      #1;
      chk($sformatf("fill_ready_%0d", i), 128'(xr), 128'(1));
      tick();
      chk($sformatf("fill_nv_%0d", i), 128'(iv), 128'(1));
      chk($sformatf("fill_id_%0d", i), 128'(iid), 128'(i));
      chk($sformatf("fill_ch_%0d", i), 128'(ich), 128'(0));
    end
    xdata = 128'h0E;
    #1;
    chk("ch0_full_ready", 128'(xr), 128'(0));
    xch = 2'd1; xdata = 128'h1E;
    #1;
    chk("ch1_ready", 128'(xr), 128'(1));
    tick();
    chk("ch1_notify", 128'({ich, iid}), 128'({2'd1, 8'd0}));
    xv = 1'b0;
    tick();
    chk("notify_cleared", 128'(iv), 128'(0));

    // Fetch ch0/id2, then reallocate id2.
    qv = 1'b1; qch = 2'd0; qid = 8'd2;
    #1;
    chk("fetch_req_ready", 128'(qr), 128'(1));
    tick();
    qv = 1'b0;
    chk("fetch_rtn_valid", 128'(rv), 128'(1));
    chk("fetch_rtn_data", rdata, 128'h0C);
    xv = 1'b1; xch = 2'd0; xdata = 128'hF0;
    #1;
    chk("realloc_ready", 128'(xr), 128'(1));
    tick();
    xv = 1'b0;
    chk("realloc_id", 128'({ich, iid}), 128'({2'd0, 8'd2}));
    chk("rtn_consumed", 128'(rv), 128'(0));
    tick();

    // ISU backpressure on channel 1.
    ir = 1'b0; xv = 1'b1; xch = 2'd1; xdata = 128'h21;
    tick();
    chk("bp_notify", 128'({iv, ich, iid}), 128'({1'b1, 2'd1, 8'd1}));
    xdata = 128'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_xready_%0d", i), 128'(xr), 128'(0));
      tick();
      chk($sformatf("bp_hold_%0d", i), 128'({iv, ich, iid}), 128'({1'b1, 2'd1, 8'd1}));
    end
    ir = 1'b1;
    #1;
    chk("bp_release_ready", 128'(xr), 128'(1));
    tick();
    chk("bp_reload", 128'({iv, ich, iid}), 128'({1'b1, 2'd1, 8'd2}));
    xv = 1'b0;
    tick();
    chk("bp_done", 128'(iv), 128'(0));

    // Return backpressure then back-to-back returns.
    rr = 1'b0; qv = 1'b1; qch = 2'd1; qid = 8'd0;
    tick();
    chk("rbp_data0", rdata, 128'h1E);
    qid = 8'd1;
    #1;
    chk("rbp_req_ready", 128'(qr), 128'(0));
    tick(); tick();
    chk("rbp_hold", 128'({rv, rdata[126:0]}), {1'b1, 127'h1E});
    rr = 1'b1;
    #1;
    chk("rbp_req_ready_up", 128'(qr), 128'(1));
    tick();
    chk("b2b_1", 128'({rv, rdata[126:0]}), {1'b1, 127'h21});
    qid = 8'd2;
    tick();
    chk("b2b_2", 128'({rv, rdata[126:0]}), {1'b1, 127'h22});
    qv = 1'b0;
    tick();
    chk("b2b_drain", 128'(rv), 128'(0));

    // Illegal fetches.
    qv = 1'b1; qch = 2'd0; qid = 8'h10;
    tick();
    chk("ill_hi_data", 128'({rv, rdata[126:0]}), {1'b1, 127'h0});
    chk("ill_hi_err", 128'(err), 128'(1));
    qid = 8'd0;
    tick();
    chk("ill_no_change", rdata, 128'h0A);
    chk("err_sticky", 128'(err), 128'(1));
    qch = 2'd1; qid = 8'd0;
    tick();
    chk("ill_free_data", 128'({rv, rdata[126:0]}), {1'b1, 127'h0});
    qv = 1'b0;
    tick();
    chk("err_sticky2", 128'(err), 128'(1));

    // Reset mid-operation: ch0 holds ids 1..3, return and notify pending.
    rr = 1'b0; ir = 1'b0;
    qv = 1'b1; qch = 2'd0; qid = 8'd1;
    xv = 1'b1; xch = 2'd2; xdata = 128'h33;
    tick();
    chk("pre_rst_rtn", 128'(rv), 128'(1));
    chk("pre_rst_notify", 128'(iv), 128'(1));
    qv = 1'b0; xv = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; rr = 1'b1; ir = 1'b1;
    #1;
    chk("post_rst_outs", 128'({iv, rv, err, ich, iid}), 128'(0));
    chk("post_rst_data", rdata, 128'(0));
    for (int i = 0; i < 4; i++) begin
      xv = 1'b1; xch = 2'd0; xdata = 128'(i);
      #1;
      chk($sformatf("post_rst_ready_%0d", i), 128'(xr), 128'(1));
      tick();
      chk($sformatf("post_rst_id_%0d", i), 128'(iid), 128'(i));
    end
    #1;
    chk("post_rst_full", 128'(xr), 128'(0));
    xv = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
